// File: rtl/base_arb_rr_lock_pkg.sv
// ---------------------------------------------------------------------------
// base_arb_rr_lock_pkg
// Shared types and width helpers for the round-robin grant-lock arbiter.
//   arb_state_t : arbiter FSM state (IDLE=0, BUSY=1)
//   min1_clog2  : $clog2 clamped to a minimum of one bit
// ---------------------------------------------------------------------------
package base_arb_rr_lock_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

   function automatic int unsigned min1_clog2(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/base_arb_rr_lock_prienc.sv
// ---------------------------------------------------------------------------
// base_prienc_hp_new
// Lowest-index-first priority encoder (index 0 has highest priority).
//   din  : request vector
//   dout : one-hot of the lowest set index of din (all-zero if din is zero)
//   kill : kill[i] = |din[0:i]; bits at and after the winner are set
// ---------------------------------------------------------------------------
module base_prienc_hp_new #(
   parameter int unsigned width = 4
) (
   input  logic [0:width-1] din,
   output logic [0:width-1] dout,
   output logic [0:width-1] kill
);

   always_comb begin : p_scan
      logic w_seen;
      w_seen = 1'b0;
      dout   = '0;
      kill   = '0;
      for (int unsigned i = 0; i < width; i++) begin
         dout[i] = din[i] & ~w_seen;
         kill[i] = din[i] | w_seen;
         w_seen  = kill[i];
      end
   end

endmodule

// File: rtl/base_arb_rr_lock.sv
// ---------------------------------------------------------------------------
// base_arb_rr_lock
// Registered round-robin arbiter with grant lock. The winner is the lowest
// requesting index inside a rotating mask (falling back to the full request
// vector when the mask hides everyone). The one-hot grant is held until the
// holder releases it or an optional hold timeout forces a release.
//   clk     : rising-edge clock
//   reset   : synchronous active-high reset
//   req     : per-way requests, index 0 highest static priority
//   rel     : holder release, ignored while idle
//   gnt     : registered one-hot grant, zero when idle
//   gnt_v   : |gnt
//   gnt_enc : binary index of the granted way, zero when idle
//   tmo     : high in the cycle a grant is force-released by timeout
// ---------------------------------------------------------------------------
module base_arb_rr_lock
   import base_arb_rr_lock_pkg::*;
#(
   parameter  int unsigned ways     = 4,
   parameter  int unsigned max_hold = 0,
   localparam int unsigned encw     = min1_clog2(ways)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [0:ways-1] req,
   input  logic            rel,
   output logic [0:ways-1] gnt,
   output logic            gnt_v,
   output logic [0:encw-1] gnt_enc,
   output logic            tmo
);

   localparam int unsigned CNTW = min1_clog2(max_hold + 1);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'((max_hold > 0) ? (max_hold - 1) : 0);

   arb_state_t       r_state;
   logic [0:ways-1]  r_gnt;
   logic [0:encw-1]  r_enc;
   logic [0:ways-1]  r_mask;
   logic [CNTW-1:0]  r_cnt;

   logic [0:ways-1]  w_masked;
   logic [0:ways-1]  w_cand;
   logic [0:ways-1]  w_win_oh;
   logic [0:ways-1]  w_kill;
   logic [0:ways-1]  w_mask_next;
   logic [0:encw-1]  w_win_enc;
   logic             w_any_req;
   logic             w_tmo_hit;
   logic             w_release;

   assign w_any_req = |req;
   assign w_masked  = req & r_mask;
   assign w_cand    = (|w_masked) ? w_masked : req;

   base_prienc_hp_new #(
      .width (ways)
   ) u_prienc (
      .din  (w_cand),
      .dout (w_win_oh),
      .kill (w_kill)
   );

   // Next mask keeps only the ways strictly after the winner.
   assign w_mask_next = w_kill & ~w_win_oh;

   always_comb begin
      w_win_enc = '0;
      for (int unsigned i = 0; i < ways; i++) begin
         if (w_win_oh[i]) begin
            w_win_enc = w_win_enc | encw'(i);
         end
      end
   end

   assign w_tmo_hit = (max_hold != 0) && (r_state == ST_BUSY) && (r_cnt == CNT_LAST);
   // A timeout acts exactly like rel; when both coincide it is a plain release.
   assign w_release = (r_state == ST_BUSY) && (rel || w_tmo_hit);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_gnt   <= '0;
         r_enc   <= '0;
         r_mask  <= '1;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_state <= ST_BUSY;
                  r_gnt   <= w_win_oh;
                  r_enc   <= w_win_enc;
                  r_mask  <= w_mask_next;
                  r_cnt   <= '0;
               end
            end
            ST_BUSY: begin
               if (w_release) begin
                  if (w_any_req) begin
                     r_gnt  <= w_win_oh;
                     r_enc  <= w_win_enc;
                     r_mask <= w_mask_next;
                     r_cnt  <= '0;
                  end else begin
                     r_state <= ST_IDLE;
                     r_gnt   <= '0;
                     r_enc   <= '0;
                     r_cnt   <= '0;
                  end
               end else if (max_hold != 0) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_gnt   <= '0;
               r_enc   <= '0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign gnt     = r_gnt;
   assign gnt_v   = |r_gnt;
   assign gnt_enc = r_enc;
   assign tmo     = w_tmo_hit & ~rel;

endmodule

// File: tb/tb_base_arb_rr_lock.sv
module tb_base_arb_rr_lock;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // ways=4, no timeout
   logic       rst_a, rel_a, gv_a, tmo_a;
   logic [0:3] req_a, gnt_a;
   logic [0:1] enc_a;
   // ways=4, max_hold=3
   logic       rst_t, rel_t, gv_t, tmo_t;
   logic [0:3] req_t, gnt_t;
   logic [0:1] enc_t;
   // ways=1
   logic       rst_o, rel_o, gv_o, tmo_o;
   logic [0:0] req_o, gnt_o;
   logic [0:0] enc_o;

   base_arb_rr_lock #(.ways(4), .max_hold(0)) u_dut (
      .clk(clk), .reset(rst_a), .req(req_a), .rel(rel_a),
      .gnt(gnt_a), .gnt_v(gv_a), .gnt_enc(enc_a), .tmo(tmo_a));

   base_arb_rr_lock #(.ways(4), .max_hold(3)) u_tmo (
      .clk(clk), .reset(rst_t), .req(req_t), .rel(rel_t),
      .gnt(gnt_t), .gnt_v(gv_t), .gnt_enc(enc_t), .tmo(tmo_t));

   base_arb_rr_lock #(.ways(1), .max_hold(0)) u_one (
      .clk(clk), .reset(rst_o), .req(req_o), .rel(rel_o),
      .gnt(gnt_o), .gnt_v(gv_o), .gnt_enc(enc_o), .tmo(tmo_o));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic       rst;
      logic [0:3] req;
      logic       rel;
      logic [0:3] gnt;
      logic [1:0] enc;
   } vec_t;

   vec_t vecs[$];

   task automatic tstep(input logic [0:3] rq, input logic rl,
                        input logic [0:3] eg, input logic et, input string nm);
      @(negedge clk);
      req_t = rq;
      rel_t = rl;
      rst_t = 1'b0;
      #1;
      check({nm, ".gnt"}, 32'(gnt_t), 32'(eg));
      check({nm, ".tmo"}, 32'(tmo_t), 32'(et));
      check({nm, ".gnt_v"}, 32'(gv_t), 32'(|eg));
   endtask

   task automatic ostep(input logic rq, input logic rl, input logic eg, input string nm);
      @(negedge clk);
      req_o = rq;
      rel_o = rl;
      rst_o = 1'b0;
      #1;
      check({nm, ".gnt"}, 32'(gnt_o), 32'(eg));
      check({nm, ".gnt_v"}, 32'(gv_o), 32'(eg));
      check({nm, ".enc"}, 32'(enc_o), 32'd0);
   endtask

   initial begin
      rst_a = 1'b1; req_a = '0; rel_a = 1'b0;
      rst_t = 1'b1; req_t = '0; rel_t = 1'b0;
      rst_o = 1'b1; req_o = '0; rel_o = 1'b0;

      //                rst   req      rel   gnt      enc
      vecs.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0}); // reset state
      vecs.push_back('{1'b0, 4'b0110, 1'b0, 4'b0100, 2'd1}); // first grant, lowest index
      for (int i = 0; i < 5; i++)
         vecs.push_back('{1'b0, 4'b1111, 1'b0, 4'b0100, 2'd1}); // locked
      vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b0010, 2'd2}); // back-to-back rotate
      vecs.push_back('{1'b0, 4'b1001, 1'b1, 4'b0001, 2'd3}); // way 3 takes it
      vecs.push_back('{1'b0, 4'b1001, 1'b1, 4'b1000, 2'd0}); // wrap to way 0
      vecs.push_back('{1'b0, 4'b0001, 1'b1, 4'b0001, 2'd3});
      vecs.push_back('{1'b0, 4'b0000, 1'b0, 4'b0001, 2'd3}); // holder drops req, still held
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0}); // release to idle
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0}); // rel in idle ignored
      vecs.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0});
      vecs.push_back('{1'b0, 4'b0110, 1'b0, 4'b0100, 2'd1}); // zero mask falls back
      vecs.push_back('{1'b0, 4'b1111, 1'b1, 4'b0010, 2'd2});
      vecs.push_back('{1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0}); // reset mid-grant
      vecs.push_back('{1'b0, 4'b0011, 1'b0, 4'b0010, 2'd2}); // mask back to all-ones
      vecs.push_back('{1'b0, 4'b0010, 1'b1, 4'b0010, 2'd2}); // same way re-wins alone
      vecs.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0});

      @(posedge clk);
      @(posedge clk);

      foreach (vecs[k]) begin
         @(negedge clk);
         rst_a = vecs[k].rst;
         req_a = vecs[k].req;
         rel_a = vecs[k].rel;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d.gnt", k), 32'(gnt_a), 32'(vecs[k].gnt));
         check($sformatf("vec%0d.enc", k), 32'(enc_a), 32'(vecs[k].enc));
         check($sformatf("vec%0d.gnt_v", k), 32'(gv_a), 32'(|vecs[k].gnt));
         check($sformatf("vec%0d.tmo", k), 32'(tmo_a), 32'd0);
      end

      // Timeout instance: inputs set at negedge, state observed before next edge.
      check("tmo.reset.gnt", 32'(gnt_t), 32'd0);
      tstep(4'b1100, 1'b0, 4'b0000, 1'b0, "tmo0");
      tstep(4'b1100, 1'b0, 4'b1000, 1'b0, "tmo1");
      tstep(4'b1100, 1'b0, 4'b1000, 1'b0, "tmo2");
      tstep(4'b1100, 1'b0, 4'b1000, 1'b1, "tmo3");
      check("tmo3.enc", 32'(enc_t), 32'd0);
      tstep(4'b1100, 1'b0, 4'b0100, 1'b0, "tmo4");
      check("tmo4.enc", 32'(enc_t), 32'd1);
      tstep(4'b1100, 1'b0, 4'b0100, 1'b0, "tmo5");
      tstep(4'b1100, 1'b1, 4'b0100, 1'b0, "tmo6_relcoinc");
      tstep(4'b0000, 1'b0, 4'b1000, 1'b0, "tmo7");
      tstep(4'b0000, 1'b0, 4'b1000, 1'b0, "tmo8");
      tstep(4'b0000, 1'b0, 4'b1000, 1'b1, "tmo9");
      tstep(4'b0000, 1'b0, 4'b0000, 1'b0, "tmo10_idle");

      // Single-way instance.
      check("one.reset.gnt", 32'(gnt_o), 32'd0);
      ostep(1'b1, 1'b0, 1'b0, "one0");
      ostep(1'b0, 1'b0, 1'b1, "one1");
      ostep(1'b1, 1'b1, 1'b1, "one2");
      ostep(1'b0, 1'b1, 1'b1, "one3_regrant");
      ostep(1'b0, 1'b0, 1'b0, "one4_idle");
      check("one.tmo", 32'(tmo_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
